spi_slave_xcvr: RTL and testbench
=================================

Name: spi_slave_xcvr

Overview:
SPI peripheral-side transceiver, the far end of the team's SPI_Master link. Oversamples SCLK/MOSI/CS_n on the local system clock, deserialises MOSI into bytes with a one-cycle valid strobe, and serialises a locally supplied byte onto MISO. Used as the on-board loopback/target for the "Hello World" SPI stream and as a generic byte-level SPI target.

Parameters:
SPI_MODE, 0, SPI mode 0..3; CPOL = SPI_MODE[1], CPHA = SPI_MODE[0]
IDLE_TIMEOUT, 64, i_Clk cycles with no SCLK edge before the bit counter resynchronises (CS-less operation); 0 disables
DEFAULT_TX, 8'hFF, byte shifted out when no TX byte is queued

Ports:
i_Clk  in  1  system clock
reset_i  in  1  asynchronous active-high reset
i_SPI_Clk  in  1  SCLK from master, asynchronous
i_SPI_MOSI  in  1  MOSI, asynchronous
i_SPI_CS_n  in  1  chip select, active low, asynchronous; tie 0 if master has no CS
o_SPI_MISO  out  1  MISO
i_TX_Byte  in  8  next byte to send
i_TX_DV  in  1  TX byte valid
o_TX_Ready  out  1  holding register empty
o_RX_Byte  out  8  last received byte
o_RX_DV  out  1  one-cycle strobe, o_RX_Byte valid
o_Frame_Err  out  1  one-cycle strobe, CS deasserted mid-byte
o_Busy  out  1  high while in ACTIVE

Behaviour:
- Reset values: o_RX_Byte 0, o_RX_DV 0, o_Frame_Err 0, o_Busy 0, o_TX_Ready 1, o_SPI_MISO = DEFAULT_TX[7]; state IDLE, bit count 0, holding register empty.
- Synchronisers: 2-FF on SCLK, MOSI, CS_n; edge detect on synchronised SCLK. Required input timing: each SCLK level held >= 2 i_Clk cycles for RX; >= 4 for MISO to meet master setup.
- Sample edge: leading edge when CPHA=0, trailing edge when CPHA=1 (leading = transition away from CPOL). Other edge is the shift edge.
- MSB first. Bit counter 0..7; on 8th sample, o_RX_Byte <= shifted byte, o_RX_DV pulses the next cycle, counter wraps to 0. RX latency: o_RX_DV high 4 i_Clk cycles after the raw 8th sample edge.
- States: IDLE -> ACTIVE on synchronised CS_n low. ACTIVE -> IDLE on CS_n high; if bit count != 0, pulse o_Frame_Err, discard partial byte, no o_RX_DV. ACTIVE stays ACTIVE across byte boundaries.
- Timeout: in ACTIVE, if IDLE_TIMEOUT != 0 and no SCLK edge for IDLE_TIMEOUT cycles with bit count != 0, bit count <= 0 and partial byte discarded, no strobe, no error.
- TX holding register: accepts i_TX_Byte when i_TX_DV && o_TX_Ready; o_TX_Ready drops the next cycle. Holding -> shifter at byte start (IDLE->ACTIVE transition, or the cycle the counter wraps to 0); o_TX_Ready reasserts the same cycle. Empty holding at byte start -> shifter loads DEFAULT_TX.
- Simultaneous i_TX_DV with byte-start load while empty: new byte goes straight to shifter, holding stays empty, o_TX_Ready stays 1.
- MISO: CPHA=0: shifter MSB driven at byte start, next bit after each shift edge. CPHA=1: next bit (first = MSB) driven after each leading edge. MISO updates 3 i_Clk after the raw SCLK edge. MISO holds last value in IDLE (no tristate).
- Reset mid-byte: all state to reset values immediately; queued TX byte lost.

Decomposition:
- Shared package spi_pkg: SPI mode constants (CPOL/CPHA extraction), state encoding IDLE/ACTIVE, bit-count width constant (3).
- One sub-module: spi_sync_edge (2-FF synchroniser + rise/fall detect), instantiated for SCLK and CS_n; MOSI uses sync only.

Test Plan:
- Mode 0, CS low, SPI_Master at CLKS_PER_HALF_BIT=2 sends 0x48,0x65,0x6C -> three o_RX_DV pulses, o_RX_Byte 0x48, 0x65, 0x6C in order, no o_Frame_Err.
- Mode 0, half-bit 4, i_TX_Byte 0xA5 queued before CS low -> master receives 0xA5; o_TX_Ready 0 until byte start, then 1; second byte with nothing queued -> master receives 0xFF.
- CS low, 5 SCLK cycles, CS high -> o_Frame_Err one pulse, no o_RX_DV; next full frame 0x3C -> o_RX_DV with 0x3C.
- CS tied low, 3 bits then 64-cycle SCLK stall, then byte 0x57 -> single o_RX_DV with 0x57.
- Modes 1, 2, 3 each: loopback 0x81 TX and 0x7E RX -> master gets 0x81, o_RX_Byte 0x7E.
- reset_i pulsed after bit 4 with 0xC3 queued -> all outputs at reset values, o_TX_Ready 1; next frame 0x21 received correctly, MISO sends 0xFF.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI peripheral-side transceiver.
package spi_pkg;

    // Width of the per-byte bit counter (counts 0..7).
    localparam int unsigned BIT_CNT_W = 3;
    localparam logic [BIT_CNT_W-1:0] BIT_CNT_LAST = 3'd7;

    // Link state: IDLE while CS_n is high, ACTIVE while a frame is open.
    typedef enum logic {
        StIdle,
        StActive
    } spi_state_e;

    // Clock polarity: idle level of SCLK.
    function automatic logic cpol_of(input int unsigned mode);
        return mode[1];
    endfunction

    // Clock phase: 0 samples on the leading edge, 1 on the trailing edge.
    function automatic logic cpha_of(input int unsigned mode);
        return mode[0];
    endfunction

endpackage

// File: rtl/spi_slave_xcvr_if.sv
// Bus bundle between an SPI target transceiver and its surroundings.
// The slave modport is the transceiver's view; master is the far side.
interface spi_slave_xcvr_if;

    logic       i_SPI_Clk;
    logic       i_SPI_MOSI;
    logic       i_SPI_CS_n;
    logic       o_SPI_MISO;
    logic [7:0] i_TX_Byte;
    logic       i_TX_DV;
    logic       o_TX_Ready;
    logic [7:0] o_RX_Byte;
    logic       o_RX_DV;
    logic       o_Frame_Err;
    logic       o_Busy;

    modport slave (
        input  i_SPI_Clk,
        input  i_SPI_MOSI,
        input  i_SPI_CS_n,
        input  i_TX_Byte,
        input  i_TX_DV,
        output o_SPI_MISO,
        output o_TX_Ready,
        output o_RX_Byte,
        output o_RX_DV,
        output o_Frame_Err,
        output o_Busy
    );

    modport master (
        output i_SPI_Clk,
        output i_SPI_MOSI,
        output i_SPI_CS_n,
        output i_TX_Byte,
        output i_TX_DV,
        input  o_SPI_MISO,
        input  o_TX_Ready,
        input  o_RX_Byte,
        input  o_RX_DV,
        input  o_Frame_Err,
        input  o_Busy
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous input plus rise/fall detection
// on the synchronised level. Edge strobes last exactly one i_Clk cycle.
module spi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_Clk,
    input  logic reset_i,
    input  logic i_Async,
    output logic o_Sync,
    output logic o_Rise,
    output logic o_Fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchronise and keep one cycle of history for edge detection.
    always_ff @(posedge i_Clk or posedge reset_i) begin
        if (reset_i) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
            r_prev <= RESET_VAL;
        end else begin
            r_meta <= i_Async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_Sync = r_sync;
    assign o_Rise = r_sync & ~r_prev;
    assign o_Fall = ~r_sync & r_prev;

endmodule

// File: rtl/spi_slave_xcvr.sv
// SPI target transceiver: oversamples SCLK/MOSI/CS_n on i_Clk, deserialises
// MOSI into bytes and serialises a locally supplied byte onto MISO.
module spi_slave_xcvr
    import spi_pkg::*;
#(
    parameter int unsigned SPI_MODE     = 0,
    parameter int unsigned IDLE_TIMEOUT = 64,
    parameter logic [7:0]  DEFAULT_TX   = 8'hFF
) (
    input  logic            i_Clk,
    input  logic            reset_i,
    spi_slave_xcvr_if.slave io_Spi
);

    localparam logic CPOL = cpol_of(SPI_MODE);
    localparam logic CPHA = cpha_of(SPI_MODE);

    localparam int unsigned    TO_W    = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT + 1) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(IDLE_TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(IDLE_TIMEOUT);
    localparam logic            TO_EN   = (IDLE_TIMEOUT != 0);

    // Synchronised inputs and edges
    logic w_sclk_sync, w_sclk_rise, w_sclk_fall;
    logic w_cs_n, w_cs_rise, w_cs_fall;
    logic r_mosi_meta, r_mosi_sync;
    logic w_lead, w_trail, w_sample_edge, w_shift_edge, w_any_edge;

    // FSM and control strobes
    spi_state_e r_state, w_state_next;
    logic w_start, w_abort, w_sample, w_shift, w_timeout, w_wrap, w_load;

    // Datapath registers
    logic [BIT_CNT_W-1:0] r_bit_cnt;
    logic [6:0]           r_rx_shift;
    logic [7:0]           w_rx_next;
    logic [7:0]           r_rx_byte;
    logic                 r_rx_done;
    logic                 r_rx_dv;
    logic                 r_frame_err;
    logic [TO_W-1:0]      r_idle_cnt;
    logic [7:0]           r_hold;
    logic                 r_hold_full;
    logic [7:0]           w_load_byte;
    logic [7:0]           r_tx_shift;
    logic                 r_miso;

    spi_sync_edge #(
        .RESET_VAL (CPOL)
    ) u_sync_sclk (
        .i_Clk   (i_Clk),
        .reset_i (reset_i),
        .i_Async (io_Spi.i_SPI_Clk),
        .o_Sync  (w_sclk_sync),
        .o_Rise  (w_sclk_rise),
        .o_Fall  (w_sclk_fall)
    );

    spi_sync_edge #(
        .RESET_VAL (1'b1)
    ) u_sync_cs (
        .i_Clk   (i_Clk),
        .reset_i (reset_i),
        .i_Async (io_Spi.i_SPI_CS_n),
        .o_Sync  (w_cs_n),
        .o_Rise  (w_cs_rise),
        .o_Fall  (w_cs_fall)
    );

    // Only the levels of CS_n and the edges of SCLK drive the logic.
    logic w_unused_sync;
    assign w_unused_sync = ^{w_sclk_sync, w_cs_rise, w_cs_fall};

    // MOSI needs no edge detect, so it gets a plain two-flop synchroniser.
    always_ff @(posedge i_Clk or posedge reset_i) begin
        if (reset_i) begin
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
        end else begin
            r_mosi_meta <= io_Spi.i_SPI_MOSI;
            r_mosi_sync <= r_mosi_meta;
        end
    end

    // Leading edge moves SCLK away from its idle level.
    assign w_lead        = CPOL ? w_sclk_fall : w_sclk_rise;
    assign w_trail       = CPOL ? w_sclk_rise : w_sclk_fall;
    assign w_sample_edge = CPHA ? w_trail : w_lead;
    assign w_shift_edge  = CPHA ? w_lead : w_trail;
    assign w_any_edge    = w_sclk_rise | w_sclk_fall;

    // State register.
    always_ff @(posedge i_Clk or posedge reset_i) begin
        if (reset_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and per-cycle control strobes.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_abort      = 1'b0;
        w_sample     = 1'b0;
        w_shift      = 1'b0;
        w_timeout    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!w_cs_n) begin
                    w_state_next = StActive;
                    w_start      = 1'b1;
                end
            end
            StActive: begin
                if (w_cs_n) begin
                    w_state_next = StIdle;
                    w_abort      = (r_bit_cnt != '0);
                end else begin
                    w_sample  = w_sample_edge;
                    w_shift   = w_shift_edge;
                    w_timeout = TO_EN && (r_idle_cnt == TO_LAST) && (r_bit_cnt != '0)
                                && !w_any_edge;
                end
            end
            default: w_state_next = StIdle;
        endcase
        w_wrap = w_sample && (r_bit_cnt == BIT_CNT_LAST);
        w_load = w_start || w_wrap;
    end

    assign w_rx_next = {r_rx_shift, r_mosi_sync};

    // Bit counter and receive shifter; an abort or timeout drops the partial byte.
    always_ff @(posedge i_Clk or posedge reset_i) begin
        if (reset_i) begin
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
        end else if (w_abort || w_timeout) begin
            r_bit_cnt  <= '0;
        end else if (w_sample) begin
            r_rx_shift <= w_rx_next[6:0];
            r_bit_cnt  <= r_bit_cnt + 1'b1;
        end
    end

    // Received byte capture, delayed valid strobe and frame-error strobe.
    always_ff @(posedge i_Clk or posedge reset_i) begin
        if (reset_i) begin
            r_rx_byte   <= '0;
            r_rx_done   <= 1'b0;
            r_rx_dv     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_wrap) begin
                r_rx_byte <= w_rx_next;
            end
            r_rx_done   <= w_wrap;
            r_rx_dv     <= r_rx_done;
            r_frame_err <= w_abort;
        end
    end

    // Cycles since the last SCLK edge while a frame is open; saturates.
    always_ff @(posedge i_Clk or posedge reset_i) begin
        if (reset_i) begin
            r_idle_cnt <= '0;
        end else if ((r_state != StActive) || w_any_edge) begin
            r_idle_cnt <= '0;
        end else if (r_idle_cnt != TO_MAX) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    // A byte offered in the very cycle an empty holding register is drained
    // bypasses it and goes straight into the shifter.
    assign w_load_byte = r_hold_full ? r_hold
                       : (io_Spi.i_TX_DV ? io_Spi.i_TX_Byte : DEFAULT_TX);

    // TX holding register.
    always_ff @(posedge i_Clk or posedge reset_i) begin
        if (reset_i) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else if (w_load) begin
            r_hold_full <= 1'b0;
        end else if (io_Spi.i_TX_DV && !r_hold_full) begin
            r_hold      <= io_Spi.i_TX_Byte;
            r_hold_full <= 1'b1;
        end
    end

    // TX shifter and MISO. CPHA=0 presents the MSB at byte start and skips the
    // trailing edge that closes a byte; CPHA=1 presents each bit on a leading edge.
    always_ff @(posedge i_Clk or posedge reset_i) begin
        if (reset_i) begin
            r_tx_shift <= DEFAULT_TX;
            r_miso     <= DEFAULT_TX[7];
        end else if (w_load) begin
            r_tx_shift <= w_load_byte;
            if (!CPHA) begin
                r_miso <= w_load_byte[7];
            end
        end else if (w_shift) begin
            if (CPHA) begin
                r_miso     <= r_tx_shift[7];
                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
            end else if (r_bit_cnt != '0) begin
                r_miso     <= r_tx_shift[6];
                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
            end
        end
    end

    assign io_Spi.o_SPI_MISO  = r_miso;
    assign io_Spi.o_TX_Ready  = ~r_hold_full;
    assign io_Spi.o_RX_Byte   = r_rx_byte;
    assign io_Spi.o_RX_DV     = r_rx_dv;
    assign io_Spi.o_Frame_Err = r_frame_err;
    assign io_Spi.o_Busy      = (r_state == StActive);

endmodule

// File: tb/tb_spi_slave_xcvr.sv
// Bench for spi_slave_xcvr: one instance per SPI mode, a behavioural SPI
// master, and a scoreboard that matches RX strobes and master-received bytes.
module tb_spi_slave_xcvr;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk;
    logic       mosi;
    logic [3:0] cs_n;
    logic [3:0] tx_dv;
    logic [7:0] tx_byte;
    logic [3:0] miso, tx_ready, rx_dv, ferr, busy;
    logic [7:0] rx_byte [4];

    int n_tests = 0;
    int n_fail  = 0;
    int n_ferr  = 0;

    logic [7:0] exp_rx[$];
    logic [7:0] exp_miso[$];
    logic [7:0] mst_q[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave_xcvr_if u_if ();
        assign u_if.i_SPI_Clk  = (g >= 2) ? ~sclk : sclk;
        assign u_if.i_SPI_MOSI = mosi;
        assign u_if.i_SPI_CS_n = cs_n[g];
        assign u_if.i_TX_Byte  = tx_byte;
        assign u_if.i_TX_DV    = tx_dv[g];
        assign miso[g]         = u_if.o_SPI_MISO;
        assign tx_ready[g]     = u_if.o_TX_Ready;
        assign rx_byte[g]      = u_if.o_RX_Byte;
        assign rx_dv[g]        = u_if.o_RX_DV;
        assign ferr[g]         = u_if.o_Frame_Err;
        assign busy[g]         = u_if.o_Busy;

        spi_slave_xcvr #(
            .SPI_MODE     (g),
            .IDLE_TIMEOUT (64),
            .DEFAULT_TX   (8'hFF)
        ) u_dut (
            .i_Clk   (clk),
            .reset_i (rst),
            .io_Spi  (u_if)
        );
    end

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboards whenever a DUT or the master presents a byte.
    always @(negedge clk) begin
        for (int g = 0; g < 4; g++) begin
            if (rx_dv[g] === 1'b1) begin
                if (exp_rx.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rx_unexpected: dut %0d got %02h expected none", g, rx_byte[g]);
                end else begin
                    chk8("rx_byte", rx_byte[g], exp_rx.pop_front());
                end
            end
            if (ferr[g] === 1'b1) n_ferr++;
        end
        while (mst_q.size() != 0) begin
            if (exp_miso.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL miso_unexpected: got %02h expected none", mst_q.pop_front());
            end else begin
                chk8("miso_byte", mst_q.pop_front(), exp_miso.pop_front());
            end
        end
    end

    task automatic cs_low(input int g, input int h);
        cs_n[g] = 1'b0;
        repeat (2 * h) @(negedge clk);
    endtask

    task automatic cs_high(input int g, input int h);
        repeat (h) @(negedge clk);
        cs_n[g] = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // Behavioural master: n bits of b, MSB first, half-bit of h cycles.
    task automatic xfer(input int g, input logic [7:0] b, input int n, input int h,
                        input bit chk);
        logic [7:0] rx = 8'h00;
        if ((g % 2) == 0) begin
            mosi = b[7];
            for (int i = 0; i < n; i++) begin
                repeat (h) @(negedge clk);
                sclk = 1'b1;
                rx = {rx[6:0], miso[g]};
                repeat (h) @(negedge clk);
                sclk = 1'b0;
                if (i < 7) mosi = b[6-i];
            end
        end else begin
            for (int i = 0; i < n; i++) begin
                repeat (h) @(negedge clk);
                sclk = 1'b1;
                mosi = b[7-i];
                repeat (h) @(negedge clk);
                sclk = 1'b0;
                rx = {rx[6:0], miso[g]};
            end
        end
        if (n == 8 && chk) mst_q.push_back(rx);
    endtask

    task automatic queue_tx(input int g, input logic [7:0] b);
        for (int i = 0; i < 100 && tx_ready[g] !== 1'b1; i++) @(negedge clk);
        chk1("tx_ready_before_queue", tx_ready[g], 1'b1);
        tx_byte  = b;
        tx_dv[g] = 1'b1;
        @(negedge clk);
        tx_dv[g] = 1'b0;
        chk1("tx_ready_after_accept", tx_ready[g], 1'b0);
    endtask

    task automatic drain();
        repeat (12) @(negedge clk);
        chkn("rx_pending", exp_rx.size(), 0);
        chkn("miso_pending", exp_miso.size(), 0);
    endtask

    task automatic chk_reset_outputs(input int g);
        chk8("reset_rx_byte", rx_byte[g], 8'h00);
        chk1("reset_rx_dv", rx_dv[g], 1'b0);
        chk1("reset_frame_err", ferr[g], 1'b0);
        chk1("reset_busy", busy[g], 1'b0);
        chk1("reset_tx_ready", tx_ready[g], 1'b1);
        chk1("reset_miso", miso[g], 1'b1);
    endtask

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        rst     = 1'b1;
        sclk    = 1'b0;
        mosi    = 1'b0;
        cs_n    = 4'hF;
        tx_dv   = 4'h0;
        tx_byte = 8'h00;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        for (int g = 0; g < 4; g++) chk_reset_outputs(g);

        // Mode 0 "Hel" stream at the fastest legal RX rate
        base = n_ferr;
        exp_rx.push_back(8'h48);
        exp_rx.push_back(8'h65);
        exp_rx.push_back(8'h6C);
        cs_low(0, 2);
        chk1("busy_in_frame", busy[0], 1'b1);
        xfer(0, 8'h48, 8, 2, 0);
        xfer(0, 8'h65, 8, 2, 0);
        xfer(0, 8'h6C, 8, 2, 0);
        cs_high(0, 2);
        drain();
        chkn("hello_no_frame_err", n_ferr - base, 0);
        chk1("busy_after_frame", busy[0], 1'b0);

        // Queued TX byte, then default byte when nothing is queued
        queue_tx(0, 8'hA5);
        exp_miso.push_back(8'hA5);
        exp_miso.push_back(8'hFF);
        exp_rx.push_back(8'h11);
        exp_rx.push_back(8'h22);
        cs_low(0, 4);
        chk1("tx_ready_after_start", tx_ready[0], 1'b1);
        xfer(0, 8'h11, 8, 4, 1);
        xfer(0, 8'h22, 8, 4, 1);
        cs_high(0, 4);
        drain();

        // CS released mid-byte, then a clean frame
        base = n_ferr;
        cs_low(0, 2);
        xfer(0, 8'hF0, 5, 2, 0);
        cs_high(0, 2);
        chkn("frame_err_pulse", n_ferr - base, 1);
        exp_rx.push_back(8'h3C);
        cs_low(0, 2);
        xfer(0, 8'h3C, 8, 2, 0);
        cs_high(0, 2);
        drain();
        chkn("frame_err_after_clean", n_ferr - base, 1);

        // CS held low: partial byte, SCLK stall past the timeout, then a byte
        base = n_ferr;
        cs_n[0] = 1'b0;
        repeat (4) @(negedge clk);
        xfer(0, 8'hA0, 3, 2, 0);
        repeat (70) @(negedge clk);
        exp_rx.push_back(8'h57);
        xfer(0, 8'h57, 8, 2, 0);
        cs_high(0, 2);
        drain();
        chkn("timeout_no_frame_err", n_ferr - base, 0);

        // Loopback in modes 1..3
        for (int g = 1; g < 4; g++) begin
            queue_tx(g, 8'h81);
            exp_miso.push_back(8'h81);
            exp_rx.push_back(8'h7E);
            cs_low(g, 4);
            xfer(g, 8'h7E, 8, 4, 1);
            cs_high(g, 4);
            drain();
        end

        // Reset mid-byte with a byte queued; the queued byte must be lost
        cs_low(0, 4);
        xfer(0, 8'h00, 4, 4, 0);
        queue_tx(0, 8'hC3);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs(0);
        cs_n[0] = 1'b1;
        mosi    = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk_reset_outputs(0);
        exp_rx.push_back(8'h21);
        exp_miso.push_back(8'hFF);
        cs_low(0, 4);
        xfer(0, 8'h21, 8, 4, 1);
        cs_high(0, 4);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
